// File: rtl/or_path_tester.sv
// or_path_tester
// Self-running stimulus/checker for a WIDTH-bit bitwise-OR unit. On an
// accepted start it drives a sequence of pseudo-random operand pairs
// (two 32-bit Fibonacci LFSRs), waits settle_cycles+1 cycles per pair, then
// compares the returned result against dut_a|dut_b and accumulates a
// saturating mismatch count plus the index and bit mask of the first
// mismatch.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   start            : begin a run (accepted only in IDLE)
//   num_vectors      : vectors per run, latched at start
//   settle_cycles    : extra wait cycles per vector, latched at start
//   seed             : LFSR seed, used at start
//   dut_a, dut_b     : registered operands to the unit under test
//   dut_result       : result returned by the unit under test
//   busy, done, pass : run status (done is a one-cycle pulse)
//   err_count        : mismatching vectors in the current/last run
//   first_err_idx    : index of the first mismatching vector
//   first_err_mask   : dut_result ^ (dut_a|dut_b) of the first mismatch
//
// The LFSR taps and the seed half-swap are defined on 32 bits, so WIDTH is
// expected to stay at 32.
module or_path_tester #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [3:0]       settle_cycles,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_mask
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] nvec_r;
  logic [CNT_W-1:0] idx_r;
  logic [3:0]       settle_r;
  logic [3:0]       wait_r;

  logic load_run;
  logic load_empty;
  logic cap_en;
  logic adv_en;
  logic fin_en;
  logic last_vec;
  logic mismatch;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] q);
    return {q[WIDTH-2:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
  endfunction

  // An all-zero LFSR state would lock up, so it is replaced by 1.
  function automatic logic [WIDTH-1:0] nonzero(input logic [WIDTH-1:0] q);
    return (q == '0) ? WIDTH'(1) : q;
  endfunction

  function automatic logic [WIDTH-1:0] init_a(input logic [WIDTH-1:0] s);
    return nonzero(s);
  endfunction

  function automatic logic [WIDTH-1:0] init_b(input logic [WIDTH-1:0] s);
    return nonzero(WIDTH'({s[15:0], s[31:16]} ^ 32'h5A5A5A5A));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  assign last_vec = (idx_r == nvec_r - CNT_W'(1));
  assign mismatch = (dut_result != (dut_a | dut_b));

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (num_vectors != '0) ? S_SETTLE : S_DONE;
      S_SETTLE:  if (wait_r == 4'd0) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = last_vec ? S_DONE : S_SETTLE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ---- control decode ----
  always_comb begin
    load_run   = 1'b0;
    load_empty = 1'b0;
    cap_en     = 1'b0;
    adv_en     = 1'b0;
    fin_en     = 1'b0;
    case (state)
      S_IDLE: begin
        load_run   = start && (num_vectors != '0);
        load_empty = start && (num_vectors == '0);
      end
      S_CAPTURE: begin
        cap_en = 1'b1;
        adv_en = !last_vec;
      end
      S_DONE:  fin_en = 1'b1;
      default: ;
    endcase
  end

  // ---- datapath / result registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      dut_a          <= '0;
      dut_b          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_mask <= '0;
      nvec_r         <= '0;
      idx_r          <= '0;
      settle_r       <= '0;
      wait_r         <= '0;
    end else begin
      done <= 1'b0;

      if (load_run) begin
        nvec_r         <= num_vectors;
        settle_r       <= settle_cycles;
        wait_r         <= settle_cycles;
        idx_r          <= '0;
        dut_a          <= init_a(seed);
        dut_b          <= init_b(seed);
        err_count      <= '0;
        first_err_idx  <= '0;
        first_err_mask <= '0;
        pass           <= 1'b0;
        busy           <= 1'b1;
      end else if (load_empty) begin
        err_count      <= '0;
        first_err_idx  <= '0;
        first_err_mask <= '0;
        pass           <= 1'b0;
      end

      if (state == S_SETTLE && wait_r != 4'd0) wait_r <= wait_r - 4'd1;

      // err_count is still zero only until the first mismatch is seen.
      if (cap_en && mismatch) begin
        err_count <= sat_inc(err_count);
        if (err_count == '0) begin
          first_err_idx  <= idx_r;
          first_err_mask <= dut_result ^ (dut_a | dut_b);
        end
      end

      if (adv_en) begin
        dut_a  <= lfsr_next(dut_a);
        dut_b  <= lfsr_next(dut_b);
        wait_r <= settle_r;
        idx_r  <= idx_r + CNT_W'(1);
      end

      if (fin_en) begin
        done <= 1'b1;
        busy <= 1'b0;
        pass <= (err_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_or_path_tester.sv
// Testbench for or_path_tester: loops the operands back through a modelled
// OR unit with selectable faults, predicts every output from a timeline model
// of each run, and compares on every falling edge.
module tb_or_path_tester;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic [3:0]       settle_cycles;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] dut_a, dut_b, dut_result;
  logic             busy, done, pass;
  logic [CNT_W-1:0] err_count, first_err_idx;
  logic [WIDTH-1:0] first_err_mask;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;
  int cyc = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  // Modelled unit under test: 0 = golden OR, 1 = result bit 5 stuck at 0,
  // 2 = one bit flipped whenever a[2:0]==5.
  function automatic logic [31:0] unit_out(input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [31:0] r;
    r = a | b;
    if (mode == 1) r[5] = 1'b0;
    if (mode == 2 && a[2:0] == 3'd5) r = r ^ (32'h1 << b[4:0]);
    return r;
  endfunction

  assign dut_result = unit_out(dut_a, dut_b, fault_mode);

  or_path_tester #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
    .settle_cycles(settle_cycles), .seed(seed), .dut_a(dut_a), .dut_b(dut_b),
    .dut_result(dut_result), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx), .first_err_mask(first_err_mask)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] q);
    return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
  endfunction

  // Run timeline model: a run accepted at edge c0 with N vectors and settle s
  // takes T=N*(s+2) edges; vector j is on the bus from edge c0+j*(s+2) and is
  // judged at edge c0+(j+1)*(s+2); done is seen after edge c0+T+1.
  bit          have_run = 0;
  int          c0, m_n, m_s, m_t;
  logic [31:0] va[$], vb[$], mmask[$];
  logic [31:0] held_a, held_b;
  logic [31:0] e_a, e_b, e_fmask;
  logic [15:0] e_err, e_fidx;
  logic        e_busy, e_done, e_pass;

  task automatic model_eval();
    int k, per, j, cap, tot;
    e_a = 0; e_b = 0; e_busy = 0; e_done = 0; e_pass = 0;
    e_err = 0; e_fidx = 0; e_fmask = 0;
    if (have_run) begin
      k = cyc - c0;
      per = m_s + 2;
      cap = 0;
      if (m_n == 0) begin
        e_a = held_a; e_b = held_b;
      end else begin
        j = (k >= m_t) ? m_n - 1 : k / per;
        e_a = va[j]; e_b = vb[j];
        cap = (k >= m_t) ? m_n : k / per;
      end
      tot = 0;
      for (int i = 0; i < m_n; i++) begin
        if (mmask[i] != 0) begin
          if (i < cap) begin
            if (e_err == 0) begin e_fidx = 16'(i); e_fmask = mmask[i]; end
            e_err++;
          end
          tot++;
        end
      end
      e_busy = (m_n != 0) && (k <= m_t);
      e_done = (k == m_t + 1);
      e_pass = (k >= m_t + 1) && (tot == 0);
    end
  endtask

  // Model update on each rising edge (inputs are stable here).
  initial forever begin
    logic [31:0] a, b;
    @(posedge clk);
    cyc = cyc + 1;
    if (reset === 1'b1) begin
      have_run = 0;
    end else if (start === 1'b1 && (!have_run || (cyc - c0) >= m_t + 2)) begin
      model_eval();
      held_a = e_a; held_b = e_b;
      have_run = 1;
      c0 = cyc;
      m_n = int'(num_vectors);
      m_s = int'(settle_cycles);
      m_t = m_n * (m_s + 2);
      va.delete(); vb.delete(); mmask.delete();
      a = seed;
      b = {seed[15:0], seed[31:16]} ^ 32'h5A5A5A5A;
      if (a == 0) a = 1;
      if (b == 0) b = 1;
      for (int i = 0; i < m_n; i++) begin
        va.push_back(a); vb.push_back(b);
        mmask.push_back(unit_out(a, b, fault_mode) ^ (a | b));
        a = step(a); b = step(b);
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      model_eval();
      check("dut_a", dut_a, e_a);
      check("dut_b", dut_b, e_b);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("pass", pass, e_pass);
      check("err_count", err_count, e_err);
      check("first_err_idx", first_err_idx, e_fidx);
      check("first_err_mask", first_err_mask, e_fmask);
    end
  end

  int          t_start, done_pulses;
  bit          busy_seen;
  logic [31:0] snap0_a, snap0_b, snap2_a, snap2_b;

  task automatic run(input logic [31:0] sd, input int n, input int s, input int mode,
                     input int pulse_k, output int kd);
    int budget, k;
    budget = n * (s + 2) + 4;
    @(negedge clk);
    seed = sd; num_vectors = CNT_W'(n); settle_cycles = 4'(s); fault_mode = mode;
    start = 1'b1;
    t_start = cyc + 1;
    kd = -1; done_pulses = 0; busy_seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      k = cyc - t_start;
      start = (k + 1 == pulse_k);
      if (k == 0) begin snap0_a = dut_a; snap0_b = dut_b; end
      if (k == 2) begin snap2_a = dut_a; snap2_b = dut_b; end
      busy_seen = busy_seen | (busy === 1'b1);
      if (done === 1'b1) begin
        done_pulses++;
        if (kd < 0) kd = k;
      end
    end
    start = 1'b0;
    check("done_pulses", done_pulses, 1);
  endtask

  initial begin
    int kd, n, s, mode, pk;
    logic [31:0] sd;
    reset = 1'b1; start = 1'b0; num_vectors = '0; settle_cycles = '0; seed = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_dut_a", dut_a, 0);
    check("rst_dut_b", dut_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_count", err_count, 0);
    check("rst_first_err_mask", first_err_mask, 0);
    reset = 1'b0;

    // Golden loopback, seed 1, 16 vectors, no settle.
    run(32'h1, 16, 0, 0, -1, kd);
    check("golden_v0_a", snap0_a, 32'h00000001);
    check("golden_v0_b", snap0_b, 32'h5A5B5A5A);
    check("golden_v1_a", snap2_a, 32'h00000003);
    check("golden_v1_b", snap2_b, 32'hB4B6B4B5);
    check("golden_done_latency", kd, 33);
    check("golden_pass", pass, 1);
    check("golden_err_count", err_count, 0);

    // Result bit 5 stuck at 0.
    s = $urandom_range(0, 3);
    run($urandom, 64, s, 1, -1, kd);
    check("bit5_done_latency", kd, 64 * (s + 2) + 1);
    check("bit5_first_err_mask", first_err_mask, 32'h00000020);
    check("bit5_pass", pass, 0);
    check("bit5_err_nonzero", err_count != 0, 1);

    // Empty run.
    run($urandom, 0, 5, 0, -1, kd);
    check("empty_done_latency", kd, 1);
    check("empty_busy_seen", busy_seen, 0);
    check("empty_pass", pass, 1);

    // Reset during vector 3 (settle 1 -> vector 3 on the bus for k=9..11).
    @(negedge clk);
    seed = $urandom; num_vectors = 10; settle_cycles = 1; fault_mode = 1;
    start = 1'b1; t_start = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - t_start < 10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_dut_a", dut_a, 0);
    reset = 1'b0;
    run($urandom, 5, 2, 0, -1, kd);
    check("after_rst_done_latency", kd, 21);
    check("after_rst_pass", pass, 1);

    // Long settle with an ignored start pulse in the middle of vector 1.
    run($urandom, 2, 15, 0, 20, kd);
    check("settle15_done_latency", kd, 35);

    // Seeds that hit the zero-replacement rule.
    run(32'h0, 3, 0, 0, -1, kd);
    check("seed0_v0_a", snap0_a, 32'h00000001);
    check("seed0_v0_b", snap0_b, 32'h5A5A5A5A);
    run(32'h5A5A5A5A, 3, 1, 2, -1, kd);
    check("seed5a_v0_a", snap0_a, 32'h5A5A5A5A);
    check("seed5a_v0_b", snap0_b, 32'h00000001);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 20);
      s = $urandom_range(0, 15);
      mode = $urandom_range(0, 2);
      pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n * (s + 2))) : -1;
      sd = $urandom;
      run(sd, n, s, mode, pk, kd);
      check("rand_done_latency", kd, n * (s + 2) + 1);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/or_path_tester.md
OR_PATH_TESTER -- requirements
Module: or_path_tester

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width.
REQ-002 SHALL have parameter CNT_W, default 16: vector-count and error-count width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: begin run when sampled high in IDLE.
REQ-006 SHALL have port num_vectors  input  CNT_W: vectors per run, latched at start.
REQ-007 SHALL have port settle_cycles  input  4: extra wait cycles per vector (0..15), latched at start.
REQ-008 SHALL have port seed  input  WIDTH: LFSR seed, latched at start.
REQ-009 SHALL have port dut_a  output  WIDTH: registered operand A to the OR unit under test.
REQ-010 SHALL have port dut_b  output  WIDTH: registered operand B to the OR unit under test.
REQ-011 SHALL have port dut_result  input  WIDTH: result returned by the unit under test.
REQ-012 SHALL have port busy  output  1: high from the cycle after start until DONE.
REQ-013 SHALL have port done  output  1: one-cycle pulse at run end.
REQ-014 SHALL have port pass  output  1: high when the last completed run had zero mismatches.
REQ-015 SHALL have port err_count  output  CNT_W: mismatching vectors in the current/last run.
REQ-016 SHALL have port first_err_idx  output  CNT_W: zero-based index of the first mismatching vector.
REQ-017 SHALL have port first_err_mask  output  WIDTH: dut_result XOR (dut_a|dut_b) for the first mismatch.

Function
REQ-018 SHALL implement FSM states IDLE, SETTLE, CAPTURE, DONE.
REQ-019 IDLE, start=1, num_vectors!=0: SHALL latch the parameters, load both LFSRs, drive the first vector on dut_a/dut_b, clear err_count/first_err_*/pass, load wait=settle_cycles, and go to SETTLE.
REQ-020 IDLE, start=1, num_vectors==0: SHALL go to DONE with err_count=0 and pass=1.
REQ-021 SETTLE: SHALL go to CAPTURE if wait==0, else decrement wait; dut_a/dut_b SHALL be held stable.
REQ-022 CAPTURE: SHALL compare dut_result with dut_a|dut_b and, on mismatch, increment err_count (saturating at all-ones); on the first mismatch it SHALL record first_err_idx and first_err_mask.
REQ-023 CAPTURE, last vector: SHALL go to DONE; otherwise it SHALL advance both LFSRs, drive the next vector, reload wait, increment the index, and go to SETTLE.
REQ-024 Per-vector time SHALL be settle_cycles+2 cycles; dut_result SHALL be sampled settle_cycles+2 edges after the vector is applied.
REQ-025 DONE: SHALL assert done for exactly one cycle, set pass=(err_count==0), deassert busy, and return to IDLE.
REQ-026 Results and dut_a/dut_b SHALL hold their values in IDLE until the next accepted start.
REQ-027 start while busy SHALL be ignored.
REQ-028 LFSR step SHALL be: shift left, bit0 = q[31]^q[21]^q[1]^q[0].
REQ-029 LFSR_A init SHALL be seed; LFSR_B init SHALL be {seed[15:0],seed[31:16]} ^ 32'h5A5A5A5A; any zero init SHALL be replaced with 32'h00000001.
REQ-030 Vector 0 SHALL be the init values; vector k SHALL be the init values stepped k times.

Reset
REQ-031 reset=1 at an edge SHALL force IDLE and clear dut_a, dut_b, busy, done, pass, err_count, first_err_idx, first_err_mask, and internal counters to 0, including mid-run; reset SHALL take priority over start.

Verification
REQ-032 Reset applied -> all outputs 0 on the next cycle; state IDLE.
REQ-033 Golden OR looped back; seed=0x00000001, num_vectors=16, settle=0 -> first vector dut_a=0x00000001 and dut_b=0x5A5B5A5A; done pulses 33 cycles after start is sampled; pass=1; err_count=0.
REQ-034 Result bit 5 forced to 0; num_vectors=64 -> err_count equals the model count of vectors with a[5]|b[5]=1; first_err_mask=0x00000020; pass=0.
REQ-035 num_vectors=0 -> done on the cycle after start; pass=1; busy never asserted.
REQ-036 reset asserted during vector 3 -> busy=0 and err_count=0 on the next cycle; a new start then runs normally.
REQ-037 settle=15, num_vectors=2, start re-pulsed while busy -> each vector takes 17 cycles; the extra start is ignored; exactly one done pulse.
